// File: rtl/pifo_calendar_sched.sv
// pifo_calendar_sched: front-end controller for the root PIFO calendar.
// Arbitrates enqueue/dequeue and sequences CPU access to the calendar.
module pifo_calendar_sched #(
   parameter int PIFO_CALENDAR_SIZE        = 1024,
   parameter int PIFO_CALENDAR_INDEX_WIDTH = 10,
   parameter int PIFO_ROOT_WIDTH           = 32,
   parameter int BUFFER_ADDR_WIDTH         = 12,
   parameter int ROOT_PIFO_INFO_VALID_POS  = 31
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic                                 s_enq_valid,
   output logic                                 s_enq_ready,
   input  logic [PIFO_ROOT_WIDTH-1:0]           s_enq_data,
   input  logic                                 s_deq_valid,
   output logic                                 s_deq_ready,
   output logic                                 m_deq_valid,
   output logic [PIFO_ROOT_WIDTH-1:0]           m_deq_data,
   output logic [BUFFER_ADDR_WIDTH-1:0]         m_deq_buffer_addr,
   output logic [PIFO_CALENDAR_INDEX_WIDTH:0]   occupancy,
   output logic                                 err_invalid_drop,
   input  logic                                 cpu_req_valid,
   output logic                                 cpu_req_ready,
   input  logic                                 cpu_req_write,
   input  logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] cpu_req_addr,
   input  logic [PIFO_ROOT_WIDTH-1:0]           cpu_req_wdata,
   output logic                                 cpu_resp_valid,
   output logic [PIFO_ROOT_WIDTH-1:0]           cpu_resp_rdata,
   output logic [PIFO_ROOT_WIDTH-1:0]           cal_info_root,
   output logic                                 cal_insert_en,
   output logic                                 cal_pop_en,
   input  logic [PIFO_ROOT_WIDTH-1:0]           cal_top,
   output logic                                 cal_cpu_rd_valid,
   output logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] cal_cpu_rd_addr,
   output logic                                 cal_cpu_wr_valid,
   output logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] cal_cpu_wr_addr,
   output logic [PIFO_ROOT_WIDTH-1:0]           cal_cpu_wr_data,
   input  logic                                 cal_cpu_rd_result_valid,
   input  logic [PIFO_ROOT_WIDTH-1:0]           cal_cpu_rd_result,
   input  logic                                 cal_cpu_wr_result_valid
);

   localparam int OW = PIFO_CALENDAR_INDEX_WIDTH + 1;
   localparam int VP = ROOT_PIFO_INFO_VALID_POS;
   localparam logic [OW-1:0] OCC_LAST = OW'(PIFO_CALENDAR_SIZE - 1);
   localparam logic [OW-1:0] OCC_ONE  = OW'(1);

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      WR_WAIT
   } state_t;

   typedef enum logic {
      G_INS,
      G_POP
   } grant_t;

   state_t        state;
   state_t        state_nxt;
   grant_t        last_grant;
   logic [OW-1:0] occ;

   logic rd_acc;
   logic wr_acc;
   logic rd_done;
   logic wr_done;
   logic stall;
   logic ins_elig;
   logic pop_elig;
   logic ins_gnt;
   logic pop_gnt;
   logic ins_ok;

   // CPU request decode; combinational outputs are held low during reset
   always_comb begin
      cpu_req_ready = rstn && (state == IDLE);
      rd_acc        = cpu_req_ready && cpu_req_valid && !cpu_req_write;
      wr_acc        = cpu_req_ready && cpu_req_valid && cpu_req_write;
      rd_done       = (state == RD_WAIT) && cal_cpu_rd_result_valid;
      wr_done       = (state == WR_WAIT) && cal_cpu_wr_result_valid;
      stall         = (state == WR_WAIT);
   end

   // Calendar CPU port, issued in the accept cycle
   always_comb begin
      cal_cpu_rd_valid = rd_acc;
      cal_cpu_rd_addr  = rd_acc ? cpu_req_addr : '0;
      cal_cpu_wr_valid = wr_acc;
      cal_cpu_wr_addr  = wr_acc ? cpu_req_addr : '0;
      cal_cpu_wr_data  = wr_acc ? cpu_req_wdata : '0;
   end

   // FSM next state: wait for the calendar to finish the CPU access
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (wr_acc) begin
               state_nxt = WR_WAIT;
            end else if (rd_acc) begin
               state_nxt = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (rd_done) begin
               state_nxt = IDLE;
            end
         end
         WR_WAIT: begin
            if (wr_done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Eligibility: last atom stays empty, pops need a valid head
   always_comb begin
      ins_elig = rstn && s_enq_valid && !stall && (occ < OCC_LAST);
      pop_elig = rstn && s_deq_valid && !stall && (occ != '0)
                 && cal_top[VP];
      ins_ok   = s_enq_data[VP];
   end

   // Single-grant arbiter, round-robin only when both sides compete
   always_comb begin
      ins_gnt = 1'b0;
      pop_gnt = 1'b0;
      unique case (1'b1)
         (ins_elig && pop_elig): begin
            if (last_grant == G_INS) begin
               pop_gnt = 1'b1;
            end else begin
               ins_gnt = 1'b1;
            end
         end
         (ins_elig && !pop_elig): ins_gnt = 1'b1;
         (!ins_elig && pop_elig): pop_gnt = 1'b1;
         default: ;
      endcase
   end

   // Handshakes and calendar commands follow the grant directly
   always_comb begin
      s_enq_ready   = ins_gnt;
      s_deq_ready   = pop_gnt;
      cal_insert_en = ins_gnt && ins_ok;
      cal_pop_en    = pop_gnt;
      cal_info_root = cal_insert_en ? s_enq_data : '0;
   end

   // Occupancy, round-robin pointer and popped-element capture
   always_ff @(posedge clk) begin
      if (!rstn) begin
         occ              <= '0;
         last_grant       <= G_INS;
         m_deq_valid      <= 1'b0;
         m_deq_data       <= '0;
         err_invalid_drop <= 1'b0;
      end else begin
         m_deq_valid      <= pop_gnt;
         err_invalid_drop <= ins_gnt && !ins_ok;
         if (pop_gnt) begin
            m_deq_data <= cal_top;
            last_grant <= G_POP;
            occ        <= occ - OCC_ONE;
         end else if (ins_gnt) begin
            last_grant <= G_INS;
            if (ins_ok) begin
               occ <= occ + OCC_ONE;
            end
         end
      end
   end

   // CPU response: one pulse the cycle after the calendar answers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cpu_resp_valid <= 1'b0;
         cpu_resp_rdata <= '0;
      end else begin
         cpu_resp_valid <= rd_done || wr_done;
         if (rd_done) begin
            cpu_resp_rdata <= cal_cpu_rd_result;
         end
      end
   end

   assign occupancy         = occ;
   assign m_deq_buffer_addr = m_deq_data[BUFFER_ADDR_WIDTH-1:0];

endmodule
